// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline control path (sequencer and decoder).
package pipeline_ctrl_pkg;

   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [6:0] R_TYPE = 7'b0110011;
   localparam logic [6:0] I_TYPE = 7'b0010011;
   localparam logic [6:0] LW     = 7'b0000011;
   localparam logic [6:0] SW     = 7'b0100011;
   localparam logic [6:0] BR     = 7'b1100011;
   localparam logic [6:0] HALT   = 7'b1111111;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      HALTED
   } seq_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection between the EX load and the ID instruction.
module hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs2,
   output logic                  load_use
);

   // x0 is hardwired to zero, so a load into it can never create a dependency.
   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipeline_sequencer.sv
// Stage-enable, flush and bubble generation for the five-stage pipeline, including halt drain,
// memory wait freezes, a saturating stall counter and a sticky memory-timeout flag.
module pipeline_sequencer
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_DEPTH = 3,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs2,
   input  logic                  id_halt,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_branch_taken,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic                  idex_bubble,
   output logic                  pipe_freeze,
   output logic                  halted,
   output logic [15:0]           stall_count,
   output logic                  mem_error
);

   localparam int unsigned DCW = (DRAIN_DEPTH > 1) ? $clog2(DRAIN_DEPTH) : 1;
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_DEPTH - 1);

   seq_state_e     state_q, state_d;
   logic [DCW-1:0] drain_q, drain_d;
   logic [15:0]    wait_cnt_q, wait_cnt_d;
   logic [15:0]    stall_q, stall_d;
   logic           mem_error_q, mem_error_d;
   logic           load_use;
   logic           mem_wait;

   hazard_detect u_hazard_detect (
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs2 (id_uses_rs2),
      .load_use    (load_use)
   );

   assign mem_wait = mem_req && !mem_ready;

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_freeze = 1'b0;
      halted      = 1'b0;
      state_d     = state_q;
      drain_d     = drain_q;

      unique case (state_q)
         HALTED: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            pipe_freeze = 1'b1;
            halted      = 1'b1;
         end
         DRAIN: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            if (mem_wait) begin
               pipe_freeze = 1'b1;
            end else begin
               idex_bubble = 1'b1;
               if (drain_q == DRAIN_LAST) begin
                  state_d = HALTED;
               end else begin
                  drain_d = drain_q + 1'b1;
               end
            end
         end
         default: begin
            if (mem_wait) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               pipe_freeze = 1'b1;
            end else if (ex_branch_taken) begin
               // A halt in ID sits on the wrong path and is squashed with the flush.
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
            end else if (load_use) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
            end else if (id_halt) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               state_d     = DRAIN;
               drain_d     = '0;
            end
         end
      endcase
   end

   always_comb begin
      wait_cnt_d  = wait_cnt_q;
      stall_d     = stall_q;
      mem_error_d = mem_error_q;
      if (state_q != HALTED) begin
         if (mem_wait) begin
            if (wait_cnt_q != 16'hFFFF) begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
            if ((32'(wait_cnt_q) + 32'd1) >= MEM_TIMEOUT) begin
               mem_error_d = 1'b1;
            end
         end else begin
            wait_cnt_d = '0;
         end
         if ((mem_wait || load_use) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         drain_q     <= '0;
         wait_cnt_q  <= '0;
         stall_q     <= '0;
         mem_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_q     <= stall_d;
         mem_error_q <= mem_error_d;
      end
   end

   assign stall_count = stall_q;
   assign mem_error   = mem_error_q;

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Sequential control block for the five-stage RISC-V pipeline. It sits beside the decoder and generates every stage-enable, flush and bubble signal the datapath registers consume. It handles load-use stalls, taken-branch flushes, data-memory wait states and an orderly drain on the halt opcode (7'b1111111). It also maintains a saturating stall counter and a sticky memory-timeout flag.

## Interface
Parameters:
- DRAIN_DEPTH, default 3: cycles needed for instructions older than the halt (EX, MEM, WB) to retire.
- MEM_TIMEOUT, default 255: consecutive wait cycles before mem_error sets. Range 1..65535.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_uses_rs2  in  1  ID instruction reads rs2 (R-type, SW, BEQ).
- id_halt  in  1  decoded Halt of the ID instruction.
- ex_mem_read  in  1  MemRead of the instruction in EX.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch in EX is resolved taken.
- mem_req  in  1  MemRead or MemWrite of the instruction in MEM.
- mem_ready  in  1  data memory completes the MEM-stage access this cycle.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID load NOP.
- idex_bubble  out  1  ID/EX load zeroed control (bubble).
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB; suppress register-file and memory writes.
- halted  out  1  pipeline fully drained and stopped.
- stall_count  out  16  saturating count of stall cycles.
- mem_error  out  1  sticky; a memory wait reached MEM_TIMEOUT.

## Operation
States are RUN, DRAIN and HALTED. Reset puts the block in RUN with both counters cleared and mem_error clear.

Condition terms:
- wait = mem_req && !mem_ready.
- load_use = ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || (id_uses_rs2 && ex_rd==id_rs2)).

Priority per cycle (highest first):
- wait: pipe_freeze=1, pc_write=0, ifid_write=0, no flush, no bubble. All other events are deferred. The state does not change.
- ex_branch_taken (RUN only): pc_write=1, ifid_flush=1, idex_bubble=1. Any id_halt this cycle is squashed and no DRAIN entry occurs.
- load_use (RUN only): pc_write=0, ifid_write=0, idex_bubble=1. Halt entry is deferred until the hazard clears.
- id_halt (RUN only): pc_write=0, ifid_write=0, idex_bubble=1 (the halt itself never executes). Next state is DRAIN and drain_cnt is set to 0.
- none: pc_write=1, ifid_write=1, every other output 0.

DRAIN:
- pc_write=0, ifid_write=0, idex_bubble=1.
- drain_cnt increments on each non-wait cycle.
- When drain_cnt==DRAIN_DEPTH-1 on a non-wait cycle, the next state is HALTED.

HALTED:
- pc_write=0, ifid_write=0, pipe_freeze=1, halted=1.
- All inputs are ignored except that the counters hold.
- Exit is by rst_n only.

Counters:
- wait_cnt (16 bit) increments on each wait cycle and clears on the first cycle with wait=0.
- mem_error sets on the edge where wait_cnt reaches MEM_TIMEOUT. The freeze continues after it sets.
- stall_count increments on each cycle with wait or load_use, and saturates at 16'hFFFF.

## Timing
- Reset values: pc_write=1, ifid_write=1, every other output 0 (combinational outputs in RUN with idle inputs).
- Outputs are combinational from registered state plus the current inputs, with no added latency. A stall or flush therefore takes effect on the same edge the hazard is seen.
- Halt seen in ID at edge T: DRAIN spans T+1..T+DRAIN_DEPTH and halted=1 from T+DRAIN_DEPTH+1, provided no wait cycles occur. Each wait cycle adds one cycle.
- ex_branch_taken arriving during DRAIN cannot occur legally, because EX holds only bubbles. The block ignores it.
- rst_n asserted mid-DRAIN or mid-wait returns to RUN immediately and clears the counters and mem_error.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state enum {RUN, DRAIN, HALTED};
  - the opcode constants (R_TYPE, I_TYPE, LW, SW, BR, HALT) shared with the decoder;
  - the REG_ADDR_W=5 constant.
- Sub-module hazard_detect is purely combinational. It produces load_use from ex_mem_read, ex_rd, id_rs1, id_rs2 and id_uses_rs2.
- The FSM, counters and output priority logic live in pipeline_sequencer.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1, stall_count=1. Repeat with ex_rd=0 -> no stall.
- Branch plus halt: ex_branch_taken=1 and id_halt=1 in the same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1, state stays RUN, halted never rises.
- Halt drain: id_halt=1 at edge T with all other inputs 0 -> DRAIN for cycles T+1..T+3, halted=1 from T+4, pc_write=0 thereafter.
- Wait during drain: mem_req=1, mem_ready=0 for 2 cycles in the middle of DRAIN -> pipe_freeze=1 for those cycles, halted delayed to T+6, stall_count=2.
- Timeout: MEM_TIMEOUT=4, hold wait for 6 cycles -> mem_error=1 from the 4th edge, stays 1 after mem_ready=1, clears only on rst_n=0.
- Saturation and reset: force 65540 load_use cycles -> stall_count=16'hFFFF. Assert rst_n=0 asynchronously mid-cycle -> stall_count=0 and state RUN before the next clock edge.
